// File: rtl/buffer_stream_ctrl.sv
// buffer_stream_ctrl
//
// Control front-end for a parallel-access Buffer memory. Accepts PAR_WRITE-entry chunks
// from a producer (valid/ready) and drives the Buffer write port. Drives the Buffer read
// address and presents PAR_READ-entry sliding windows to a consumer (valid/ready),
// retiring STRIDE entries per accepted window. Owns the circular write/read pointers and
// the occupancy count; the Buffer itself holds no control state.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   clear          synchronous flush of pointers and occupancy
//   in_valid       producer chunk valid
//   in_ready       room for a full chunk (registered occupancy only)
//   in_data        chunk, entry k at [k*SIZE +: SIZE]
//   out_valid      at least PAR_READ entries held
//   out_ready      consumer accepts the current window
//   out_data       window, entry k = buffer[(rptr + k) mod MEM_SIZE]
//   level          current occupancy in entries
//   wen/waddr/din  Buffer write port
//   raddr/dout     Buffer read port (dout is combinational in raddr)
//
// MEM_SIZE need not be a power of two; pointers wrap by compare-and-subtract.
// MEM_SIZE must be at least 2 so that the pointers are at least one bit wide.

module buffer_stream_ctrl #(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned MEM_SIZE    = 4,
    parameter int unsigned PAR_WRITE   = 2,
    parameter int unsigned PAR_READ    = 3,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned ADDRES_SIZE = $clog2(MEM_SIZE),
    localparam int unsigned LEVEL_SIZE = $clog2(MEM_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PAR_WRITE*SIZE-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PAR_READ*SIZE-1:0]  out_data,
    output logic [LEVEL_SIZE-1:0]     level,
    output logic                      wen,
    output logic [ADDRES_SIZE-1:0]    waddr,
    output logic [PAR_WRITE*SIZE-1:0] din,
    output logic [ADDRES_SIZE-1:0]    raddr,
    input  logic [PAR_READ*SIZE-1:0]  dout
);

    // Pointer arithmetic is done one bit wider so ptr + increment never truncates
    // before the wrap compare.
    localparam logic [ADDRES_SIZE:0] PTR_MOD      = (ADDRES_SIZE + 1)'(MEM_SIZE);
    localparam logic [ADDRES_SIZE:0] PTR_WR_INC   = (ADDRES_SIZE + 1)'(PAR_WRITE);
    localparam logic [ADDRES_SIZE:0] PTR_RD_INC   = (ADDRES_SIZE + 1)'(STRIDE);

    // Occupancy constants; the room check is also one bit wider to avoid overflow.
    localparam logic [LEVEL_SIZE:0]   LVL_CAP_EXT  = (LEVEL_SIZE + 1)'(MEM_SIZE);
    localparam logic [LEVEL_SIZE:0]   LVL_WR_EXT   = (LEVEL_SIZE + 1)'(PAR_WRITE);
    localparam logic [LEVEL_SIZE-1:0] LVL_CAP      = LEVEL_SIZE'(MEM_SIZE);
    localparam logic [LEVEL_SIZE-1:0] LVL_WIN      = LEVEL_SIZE'(PAR_READ);
    localparam logic [LEVEL_SIZE-1:0] LVL_WR_INC   = LEVEL_SIZE'(PAR_WRITE);
    localparam logic [LEVEL_SIZE-1:0] LVL_RD_DEC   = LEVEL_SIZE'(STRIDE);

    logic [ADDRES_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDRES_SIZE-1:0] rptr_q, rptr_d;
    logic [LEVEL_SIZE-1:0]  level_q, level_d;

    logic [LEVEL_SIZE:0]    level_after_wr;
    logic                   wr_fire;
    logic                   rd_fire;

    // Advance a pointer modulo MEM_SIZE. The increment never exceeds MEM_SIZE, so a single
    // conditional subtract is enough.
    function automatic logic [ADDRES_SIZE-1:0] wrap_add(
        input logic [ADDRES_SIZE-1:0] ptr,
        input logic [ADDRES_SIZE:0]   inc
    );
        logic [ADDRES_SIZE:0] sum;
        sum = {1'b0, ptr} + inc;
        if (sum >= PTR_MOD) begin
            sum = sum - PTR_MOD;
        end
        return sum[ADDRES_SIZE-1:0];
    endfunction

    // Handshake and Buffer-port outputs. Space freed by a same-cycle read is deliberately
    // not credited to in_ready, keeping in_ready independent of out_ready.
    always_comb begin
        level_after_wr = {1'b0, level_q} + LVL_WR_EXT;
        in_ready       = !rst && (level_after_wr <= LVL_CAP_EXT);
        out_valid      = !rst && (level_q >= LVL_WIN);

        wr_fire        = in_valid && in_ready;
        rd_fire        = out_valid && out_ready;

        // wen follows the fire even under clear; the level flush makes that data dead.
        wen            = wr_fire;
        waddr          = wptr_q;
        din            = in_data;
        raddr          = rptr_q;
        out_data       = dout;
        level          = level_q;
    end

    // Next-state: clear wins over any fire in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;

        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_fire) begin
                wptr_d = wrap_add(wptr_q, PTR_WR_INC);
            end
            if (rd_fire) begin
                rptr_d = wrap_add(rptr_q, PTR_RD_INC);
            end
            // Modular intermediate is fine: the final value is always in 0..MEM_SIZE.
            level_d = level_q
                    + (wr_fire ? LVL_WR_INC : '0)
                    - (rd_fire ? LVL_RD_DEC : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Gating by level makes overflow impossible.
    a_level_bound : assert property (@(posedge clk) disable iff (rst)
        level_q <= LVL_CAP);

    // A stalled window must keep its address so out_data stays stable.
    a_stall_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !clear) |=> $stable(rptr_q));

endmodule

// File: tb/tb_buffer_stream_ctrl.sv
// Bench for buffer_stream_ctrl: u0 (defaults, MEM_SIZE=4) is driven from a table of
// per-cycle vectors; u1 (MEM_SIZE=6) runs hand sequences and a random stream checked
// against a queue of expected entries. Each DUT gets a behavioural Buffer.

module tb_buffer_stream_ctrl;

    localparam int unsigned SZ = 2;
    localparam int unsigned PW = 2;
    localparam int unsigned PR = 3;
    localparam int unsigned ST = 1;
    localparam int unsigned M0 = 4;
    localparam int unsigned M1 = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- u0 ----------------
    logic       clear0, in_valid0, in_ready0, out_valid0, out_ready0, wen0;
    logic [3:0] in_data0, din0;
    logic [5:0] out_data0, dout0;
    logic [2:0] level0;
    logic [1:0] waddr0, raddr0;
    logic [1:0] mem0 [M0];

    buffer_stream_ctrl #(
        .SIZE(SZ), .MEM_SIZE(M0), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(ST)
    ) u0 (
        .clk(clk), .rst(rst), .clear(clear0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .level(level0), .wen(wen0), .waddr(waddr0), .din(din0),
        .raddr(raddr0), .dout(dout0)
    );

    always @(posedge clk) begin
        if (wen0) begin
            for (int k = 0; k < PW; k++) begin
                mem0[2'((int'(waddr0) + k) % M0)] <= din0[k*SZ +: SZ];
            end
        end
    end

    always_comb begin
        dout0 = '0;
        for (int k = 0; k < PR; k++) begin
            dout0[k*SZ +: SZ] = mem0[2'((int'(raddr0) + k) % M0)];
        end
    end

    // ---------------- u1 ----------------
    logic       clear1, in_valid1, in_ready1, out_valid1, out_ready1, wen1;
    logic [3:0] in_data1, din1;
    logic [5:0] out_data1, dout1;
    logic [2:0] level1;
    logic [2:0] waddr1, raddr1;
    logic [1:0] mem1 [M1];

    buffer_stream_ctrl #(
        .SIZE(SZ), .MEM_SIZE(M1), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(ST)
    ) u1 (
        .clk(clk), .rst(rst), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .level(level1), .wen(wen1), .waddr(waddr1), .din(din1),
        .raddr(raddr1), .dout(dout1)
    );

    always @(posedge clk) begin
        if (wen1) begin
            for (int k = 0; k < PW; k++) begin
                mem1[3'((int'(waddr1) + k) % M1)] <= din1[k*SZ +: SZ];
            end
        end
    end

    always_comb begin
        dout1 = '0;
        for (int k = 0; k < PR; k++) begin
            dout1[k*SZ +: SZ] = mem1[3'((int'(raddr1) + k) % M1)];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       clr;
        logic       iv;
        logic [3:0] idata;
        logic       ordy;
        int         lvl;
        logic       ir;
        logic       ov;
        logic [5:0] odata;
        int         wa;
        int         ra;
        logic       wen;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic v,
                                input logic [3:0] d, input logic o, input int l,
                                input logic ir, input logic ov, input logic [5:0] od,
                                input int wa, input int ra, input logic w);
        vec_t t;
        t.rst = r; t.clr = c; t.iv = v; t.idata = d; t.ordy = o;
        t.lvl = l; t.ir = ir; t.ov = ov; t.odata = od; t.wa = wa; t.ra = ra; t.wen = w;
        return t;
    endfunction

    // u1 scoreboard: entries the consumer should see, in order, plus pointer model.
    logic [1:0] sbq [$];
    int         wp1 = 0;
    int         rp1 = 0;

    task automatic step1(input logic iv, input logic [3:0] d, input logic ordy,
                         input logic clr);
        logic exp_ir, exp_ov, fire_w, fire_r;
        @(negedge clk);
        in_valid1  = iv;
        in_data1   = d;
        out_ready1 = ordy;
        clear1     = clr;
        #1;
        exp_ir = (sbq.size() + PW) <= M1;
        exp_ov = sbq.size() >= PR;
        fire_w = iv && exp_ir;
        fire_r = ordy && exp_ov;
        check("u1_level", 32'(level1), 32'(sbq.size()));
        check("u1_in_ready", 32'(in_ready1), 32'(exp_ir));
        check("u1_out_valid", 32'(out_valid1), 32'(exp_ov));
        check("u1_waddr", 32'(waddr1), 32'(wp1));
        check("u1_raddr", 32'(raddr1), 32'(rp1));
        check("u1_wen", 32'(wen1), 32'(fire_w));
        if (fire_r) begin
            for (int k = 0; k < PR; k++) begin
                check("u1_window", 32'(out_data1[k*SZ +: SZ]), 32'(sbq[k]));
            end
        end
        if (clr) begin
            sbq.delete();
            wp1 = 0;
            rp1 = 0;
        end else begin
            if (fire_r) begin
                for (int k = 0; k < ST; k++) void'(sbq.pop_front());
                rp1 = (rp1 + ST) % M1;
            end
            if (fire_w) begin
                for (int k = 0; k < PW; k++) sbq.push_back(d[k*SZ +: SZ]);
                wp1 = (wp1 + PW) % M1;
            end
        end
    endtask

    vec_t tbl [18];

    initial begin
        // Per-cycle vectors for u0: inputs, then outputs expected before that cycle's edge.
        //             rst clr iv  data     rdy lvl ir  ov  window     wa ra wen
        tbl[0]  = mk(0, 0, 0, 4'b0000, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 4'b0100, 0, 0, 1, 0, 6'b000000, 0, 0, 1);
        tbl[2]  = mk(0, 0, 1, 4'b1110, 0, 2, 1, 0, 6'b000000, 2, 0, 1);
        tbl[3]  = mk(0, 0, 1, 4'b0000, 0, 4, 0, 1, 6'b100100, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 4'b0000, 1, 4, 0, 1, 6'b100100, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 4'b0000, 1, 3, 0, 1, 6'b111001, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 4'b0000, 1, 2, 1, 0, 6'b000000, 0, 2, 0);
        tbl[7]  = mk(0, 0, 1, 4'b0001, 0, 2, 1, 0, 6'b000000, 0, 2, 1);
        tbl[8]  = mk(0, 0, 0, 4'b0000, 0, 4, 0, 1, 6'b011110, 2, 2, 0);
        tbl[9]  = mk(0, 1, 1, 4'b1111, 1, 4, 0, 1, 6'b011110, 2, 2, 0);
        tbl[10] = mk(0, 0, 0, 4'b0000, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 4'b1011, 0, 0, 1, 0, 6'b000000, 0, 0, 1);
        tbl[12] = mk(0, 1, 1, 4'b0110, 0, 2, 1, 0, 6'b000000, 2, 0, 1);
        tbl[13] = mk(0, 0, 0, 4'b0000, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 4'b0101, 0, 0, 1, 0, 6'b000000, 0, 0, 1);
        tbl[15] = mk(0, 0, 1, 4'b1010, 0, 2, 1, 0, 6'b000000, 2, 0, 1);
        tbl[16] = mk(1, 0, 1, 4'b0000, 1, 4, 0, 0, 6'b000000, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 4'b0000, 0, 0, 1, 0, 6'b000000, 0, 0, 0);

        rst = 1'b1;
        clear0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready0), 32'd0);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_level", 32'(level0), 32'd0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst        = tbl[i].rst;
            clear0     = tbl[i].clr;
            in_valid0  = tbl[i].iv;
            in_data0   = tbl[i].idata;
            out_ready0 = tbl[i].ordy;
            #1;
            check($sformatf("row%0d_level", i), 32'(level0), 32'(tbl[i].lvl));
            check($sformatf("row%0d_in_ready", i), 32'(in_ready0), 32'(tbl[i].ir));
            check($sformatf("row%0d_out_valid", i), 32'(out_valid0), 32'(tbl[i].ov));
            check($sformatf("row%0d_waddr", i), 32'(waddr0), 32'(tbl[i].wa));
            check($sformatf("row%0d_raddr", i), 32'(raddr0), 32'(tbl[i].ra));
            check($sformatf("row%0d_wen", i), 32'(wen0), 32'(tbl[i].wen));
            if (tbl[i].ov) begin
                check($sformatf("row%0d_window", i), 32'(out_data0), 32'(tbl[i].odata));
            end
        end

        // u1 was reset alongside u0 with idle inputs, so its model starts empty.
        // Simultaneous fire at level 3, with the write pointer wrapping 6 -> 0.
        step1(1'b1, 4'b1001, 1'b0, 1'b0);
        step1(1'b1, 4'b0111, 1'b0, 1'b0);
        step1(1'b0, 4'b0000, 1'b1, 1'b0);
        step1(1'b1, 4'b1100, 1'b1, 1'b0);
        @(negedge clk);
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        #1;
        check("simul_level", 32'(level1), 32'd4);
        check("simul_waddr", 32'(waddr1), 32'd0);
        check("simul_raddr", 32'(raddr1), 32'd2);

        // Random stream with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            step1($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
